fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch front end; the producer for the decode stage's pc/instr inputs.
- Issues in-order, pipelined reads to instruction memory and buffers returned 64-bit instruction words in a small prefetch FIFO.
- Presents one registered {valid, pc, instr} per cycle to decode.
- Honours the pipeline-wide stall_in, and flush_in with a redirect PC.

Parameters:
- DEPTH, 4: prefetch FIFO entries; also the maximum number of in-flight requests plus buffered entries.
- RESET_PC, 64'h0: fetch address after reset.
- INSTR_BYTES, 8: PC increment per instruction.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall_in  in  1  hold outputs and do not pop
- flush_in  in  1  discard all fetched/in-flight work and redirect
- redirect_pc_in  in  64  new fetch PC, used when flush_in=1
- imem_req_out  out  1  read request valid
- imem_addr_out  out  64  read address
- imem_ready_in  in  1  request accepted when imem_req_out && imem_ready_in
- imem_rvalid_in  in  1  response valid; in order, at least 1 cycle after acceptance, no backpressure
- imem_rdata_in  in  64  response instruction word
- valid_out  out  1  registered: instr_out/pc_out hold a real instruction
- pc_out  out  64  registered instruction PC
- instr_out  out  64  registered instruction word
- branch_predicted_taken_out  out  1  registered, always 0 (no predictor in this block)

Behaviour:
- Reset (async, active-high):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - valid_out=0, pc_out=0, instr_out=0, branch_predicted_taken_out=0.
  - Responses arriving during or after reset for pre-reset requests are not tracked. The memory must be reset together with this block.
- Credit: occupancy + outstanding < DEPTH. Responses can never be refused, so FIFO overflow is impossible.
- imem_req_out is combinational: credit && !flush_in && !reset.
- imem_addr_out = fetch_pc.
- On acceptance: fetch_pc += INSTR_BYTES (64-bit wrap-around); outstanding += 1.
- The FIFO stores {pc, instr}. A per-request PC tag FIFO of DEPTH entries pairs each accepted address with its response.
- Response handling (imem_rvalid_in=1): outstanding -= 1.
  - If drop>0: drop -= 1 and discard the data.
  - Otherwise push {tag pc, imem_rdata_in}.
  - Acceptance and response in the same cycle: outstanding is unchanged.
- Output register, when !stall_in:
  - FIFO non-empty: pop head into pc_out/instr_out; valid_out=1.
  - FIFO empty: valid_out=0; pc_out/instr_out hold their previous values.
  - A response that arrives into an empty FIFO is visible on the outputs no earlier than the next cycle (one cycle of FIFO latency; no bypass).
- When stall_in=1 and no flush: all outputs hold; no pop. Fetching and responses continue until credit runs out.
- Flush (priority over stall, push and pop):
  - FIFO and tag FIFO cleared.
  - valid_out <= 0.
  - fetch_pc <= {redirect_pc_in[63:3], 3'b0}.
  - drop <= outstanding after this cycle's response is counted; a response in the flush cycle is itself discarded.
  - No request is issued in the flush cycle.
  - Fetching resumes the next cycle and may overlap with draining the dropped responses.
- Push and pop in the same cycle on a full FIFO are legal. Occupancy is unchanged.
- Back-to-back flushes: drop is recomputed each flush. It never exceeds DEPTH.

Test Plan:
- Reset, zero-latency ready, 1-cycle rvalid, words 0xA0..:
  - valid_out first rises 3 cycles after reset deassert with pc_out=0x0, instr_out=0xA0.
  - Then pc_out=0x8, 0x10, … on consecutive cycles.
- stall_in held 10 cycles with memory always ready:
  - Outputs frozen.
  - At most DEPTH=4 requests accepted beyond the displayed instruction; imem_req_out=0 once credit is exhausted.
  - On release, PCs continue in sequence with no gap or duplicate.
- Flush with redirect_pc_in=0x1004 while 3 requests are outstanding:
  - Those 3 responses are discarded.
  - Next valid_out has pc_out=0x1000.
  - valid_out=0 the cycle after the flush.
- Flush asserted simultaneously with stall_in=1 and imem_rvalid_in=1:
  - valid_out=0 next cycle; the response is dropped; the FIFO is empty.
- imem_ready_in low for 5 cycles with an empty FIFO: valid_out=0 throughout; no spurious PC advance.
- Redirect to 0xFFFF_FFFF_FFFF_FFF8: the next sequential PC wraps to 0x0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end feeding decode.
// Issues in-order pipelined reads to instruction memory, pairs each accepted
// address with its response through a PC tag FIFO, buffers returned words in
// a prefetch FIFO, and presents one registered {valid, pc, instr} per cycle.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   stall_in                     hold outputs, no pop (fetching continues)
//   flush_in, redirect_pc_in     discard all work and refetch from redirect
//   imem_req_out/addr_out        read request and address (combinational)
//   imem_ready_in                request accepted when req && ready
//   imem_rvalid_in/rdata_in      in-order response, never back-pressured
//   valid_out/pc_out/instr_out   registered instruction to decode
//   branch_predicted_taken_out   registered, constant 0 (no predictor)
module fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned INSTR_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [63:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [63:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic        imem_rvalid_in,
  input  logic [63:0] imem_rdata_in,
  output logic        valid_out,
  output logic [63:0] pc_out,
  output logic [63:0] instr_out,
  output logic        branch_predicted_taken_out
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [63:0] fetch_pc;
  logic [63:0] fifo_pc    [DEPTH];
  logic [63:0] fifo_instr [DEPTH];
  logic [63:0] tag_pc     [DEPTH];
  ptr_t        fifo_head, fifo_tail, tag_head, tag_tail;
  cnt_t        count, outstanding, drop;

  logic        credit, accept, resp, keep, push, pop;
  logic [CW:0] inflight;

  always_comb begin
    inflight     = {1'b0, count} + {1'b0, outstanding};
    credit       = inflight < DEPTH_W;
    imem_req_out = credit && !flush_in && !reset;
    accept       = imem_req_out && imem_ready_in;
    // Responses with nothing outstanding belong to pre-reset requests.
    resp         = imem_rvalid_in && (outstanding != '0);
    keep         = resp && (drop == '0);
    push         = keep && !flush_in;
    pop          = !stall_in && !flush_in && (count != '0);
  end

  assign imem_addr_out = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      fifo_head   <= '0;
      fifo_tail   <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
    end else begin
      outstanding <= outstanding + cnt_t'(accept) - cnt_t'(resp);
      if (flush_in) begin
        // No request issues in the flush cycle, so everything still in
        // flight after this cycle's response must be discarded. The tag
        // FIFO is cleared because dropped responses never consume a tag.
        fetch_pc  <= redirect_pc_in & ~64'h7;
        drop      <= outstanding - cnt_t'(resp);
        count     <= '0;
        fifo_head <= '0;
        fifo_tail <= '0;
        tag_head  <= '0;
        tag_tail  <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 64'(INSTR_BYTES);
          tag_tail <= ptr_inc(tag_tail);
        end
        if (resp && (drop != '0)) drop <= drop - 1'b1;
        if (keep) tag_head <= ptr_inc(tag_head);
        if (push) fifo_tail <= ptr_inc(fifo_tail);
        if (pop)  fifo_head <= ptr_inc(fifo_head);
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_pc[tag_tail] <= fetch_pc;
    if (push) begin
      fifo_pc[fifo_tail]    <= tag_pc[tag_head];
      fifo_instr[fifo_tail] <= imem_rdata_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out                  <= 1'b0;
      pc_out                     <= '0;
      instr_out                  <= '0;
      branch_predicted_taken_out <= 1'b0;
    end else begin
      branch_predicted_taken_out <= 1'b0;
      if (flush_in) begin
        valid_out <= 1'b0;
      end else if (!stall_in) begin
        valid_out <= pop;
        if (pop) begin
          pc_out    <= fifo_pc[fifo_head];
          instr_out <= fifo_instr[fifo_head];
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// The instruction memory model answers each accepted request one cycle later
// (in order) with word = 0xA0 + (addr >> 3), unless responses are held.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        flush_in;
  logic [63:0] redirect_pc_in;
  logic        imem_req_out;
  logic [63:0] imem_addr_out;
  logic        imem_ready_in;
  logic        imem_rvalid_in;
  logic [63:0] imem_rdata_in;
  logic        valid_out;
  logic [63:0] pc_out;
  logic [63:0] instr_out;
  logic        branch_predicted_taken_out;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(64'h0), .INSTR_BYTES(8)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .stall_in                   (stall_in),
    .flush_in                   (flush_in),
    .redirect_pc_in             (redirect_pc_in),
    .imem_req_out               (imem_req_out),
    .imem_addr_out              (imem_addr_out),
    .imem_ready_in              (imem_ready_in),
    .imem_rvalid_in             (imem_rvalid_in),
    .imem_rdata_in              (imem_rdata_in),
    .valid_out                  (valid_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out),
    .branch_predicted_taken_out (branch_predicted_taken_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] word(input logic [63:0] a);
    return 64'hA0 + (a >> 3);
  endfunction

  // Instruction memory model
  logic [63:0] mq_addr[$];
  bit          hold_resp;
  bit          mem_acc;
  bit          mem_rst;
  logic [63:0] mem_a;

  initial begin
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = '0;
  end

  always @(posedge clk) begin
    mem_acc = imem_req_out && imem_ready_in;
    mem_a   = imem_addr_out;
    mem_rst = reset;
    #1;
    if (mem_rst) begin
      mq_addr.delete();
      imem_rvalid_in = 1'b0;
    end else begin
      if (mem_acc) mq_addr.push_back(mem_a);
      if (!hold_resp && mq_addr.size() > 0) begin
        imem_rvalid_in = 1'b1;
        imem_rdata_in  = word(mq_addr.pop_front());
      end else begin
        imem_rvalid_in = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_out && n < 20) begin
      step();
      n++;
    end
    check(tag, 64'(valid_out), 64'd1);
  endtask

  logic [63:0] exp_pc;

  initial begin
    reset          = 1'b1;
    stall_in       = 1'b0;
    flush_in       = 1'b0;
    redirect_pc_in = '0;
    imem_ready_in  = 1'b1;
    hold_resp      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_pc",    pc_out, 64'd0);
    check("rst_instr", instr_out, 64'd0);
    check("rst_bpt",   64'(branch_predicted_taken_out), 64'd0);
    check("rst_req",   64'(imem_req_out), 64'd0);
    check("rst_addr",  imem_addr_out, 64'd0);
    reset = 1'b0;

    // First instruction after accept, push, pop
    step(); check("lat1_valid", 64'(valid_out), 64'd0);
    step(); check("lat2_valid", 64'(valid_out), 64'd0);
    step();
    check("first_valid", 64'(valid_out), 64'd1);
    check("first_pc",    pc_out, 64'h0);
    check("first_instr", instr_out, 64'hA0);
    exp_pc = 64'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc += 64'd8;
      check("seq_valid", 64'(valid_out), 64'd1);
      check("seq_pc",    pc_out, exp_pc);
      check("seq_instr", instr_out, word(exp_pc));
    end

    // Stall: outputs frozen, fetch runs DEPTH ahead then stops
    stall_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", 64'(valid_out), 64'd1);
      check("stall_pc",    pc_out, exp_pc);
    end
    check("stall_req",  64'(imem_req_out), 64'd0);
    check("stall_addr", imem_addr_out, exp_pc + 64'd40);
    stall_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_pc += 64'd8;
      check("rel_valid", 64'(valid_out), 64'd1);
      check("rel_pc",    pc_out, exp_pc);
      check("rel_instr", instr_out, word(exp_pc));
    end

    // Flush to 0x2000 with memory not ready, then ready low for 5 cycles
    imem_ready_in  = 1'b0;
    flush_in       = 1'b1;
    redirect_pc_in = 64'h2000;
    step();
    flush_in = 1'b0;
    check("fl0_valid", 64'(valid_out), 64'd0);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      check("nordy_valid", 64'(valid_out), 64'd0);
      check("nordy_addr",  imem_addr_out, 64'h2000);
      check("nordy_req",   64'(imem_req_out), 64'd1);
      step();
    end

    // Three requests outstanding, then flush with unaligned redirect
    hold_resp     = 1'b1;
    imem_ready_in = 1'b1;
    repeat (3) step();
    check("out3_addr", imem_addr_out, 64'h2018);
    check("out3_req",  64'(imem_req_out), 64'd1);
    flush_in       = 1'b1;
    redirect_pc_in = 64'h1004;
    #1;
    check("flush_noreq", 64'(imem_req_out), 64'd0);
    step();
    flush_in = 1'b0;
    check("fl1_valid", 64'(valid_out), 64'd0);
    check("fl1_addr",  imem_addr_out, 64'h1000);
    hold_resp = 1'b0;
    wait_valid("fl1_wait");
    check("fl1_pc",    pc_out, 64'h1000);
    check("fl1_instr", instr_out, word(64'h1000));
    exp_pc = 64'h1000;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc += 64'd8;
      check("fl1_seq_pc",    pc_out, exp_pc);
      check("fl1_seq_instr", instr_out, word(exp_pc));
    end

    // Flush together with stall while a response is arriving
    stall_in       = 1'b1;
    flush_in       = 1'b1;
    redirect_pc_in = 64'h3000;
    step();
    flush_in = 1'b0;
    check("fs_valid", 64'(valid_out), 64'd0);
    step();
    check("fs_hold_valid", 64'(valid_out), 64'd0);
    stall_in = 1'b0;
    wait_valid("fs_wait");
    check("fs_pc",    pc_out, 64'h3000);
    check("fs_instr", instr_out, word(64'h3000));
    step();
    check("fs_next_pc", pc_out, 64'h3008);

    // Redirect to the top of the address space: next PC wraps to 0
    flush_in       = 1'b1;
    redirect_pc_in = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    flush_in = 1'b0;
    check("wrap_flush_valid", 64'(valid_out), 64'd0);
    wait_valid("wrap_wait");
    check("wrap_pc",    pc_out, 64'hFFFF_FFFF_FFFF_FFF8);
    check("wrap_instr", instr_out, word(64'hFFFF_FFFF_FFFF_FFF8));
    step();
    check("wrap_next_valid", 64'(valid_out), 64'd1);
    check("wrap_next_pc",    pc_out, 64'h0);
    check("wrap_next_instr", instr_out, 64'hA0);
    check("bpt_zero", 64'(branch_predicted_taken_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
